spi_ram: RTL

//  Command-decoding single-port RAM directly downstream of the SPI slave.
//  - Consumes the slave's 10-bit frames (rx_data/rx_valid).
//  - Executes address-load, write and read commands.
//  - Returns read data to the slave on tx_data/tx_valid for serialisation on MISO.
//  - Handles the slave's level-type rx_valid (held high for the remainder of a frame)
//    and its tx_valid expectation (high for ADDR_SIZE shifts, then low).

---
 rtl/slave_shared_pkg.sv | 18 +
 rtl/spi_ram_mem.sv | 27 ++
 rtl/spi_ram.sv | 112 +++++++++++
 3 files changed

// File: rtl/slave_shared_pkg.sv
// Shared definitions for the SPI slave and its downstream RAM.
//   ADDR_SIZE    : data and address width of a frame payload
//   cmd_e        : frame command field (din[ADDR_SIZE+1:ADDR_SIZE])
//   RAM_STATE_e  : spi_ram response FSM states
package slave_shared_pkg;

  localparam int ADDR_SIZE = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'd0,
    CMD_WR_DATA = 2'd1,
    CMD_RD_ADDR = 2'd2,
    CMD_RD_DATA = 2'd3
  } cmd_e;

  typedef enum {RAM_IDLE, RAM_RESP} RAM_STATE_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port-style RAM array with one synchronous write port and one
// synchronous read port. Contents and read register are not reset.
//   clk    : clock
//   we     : write enable, waddr/wdata written at the clock edge
//   re     : read enable, rdata <= mem[raddr] at the clock edge
//   rdata  : registered read data, holds between reads
module spi_ram_mem #(
  parameter int AW    = 8,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_ram.sv
// Command-decoding RAM behind the SPI slave. Accepts one command per rising
// edge of the slave's level-type rx_valid and returns read data with a
// tx_valid window of exactly ADDR_SIZE cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : frame, [ADDR_SIZE+1:ADDR_SIZE]=cmd, [ADDR_SIZE-1:0]=payload
//   rx_valid   : frame valid (level, may stay high for many cycles)
//   dout       : read data to slave, holds until the next read
//   tx_valid   : read data valid, high ADDR_SIZE cycles after a read
//   err        : one-cycle pulse on a read without a fresh read address,
//                or on a read command arriving while a response is active
module spi_ram #(
  parameter int ADDR_SIZE = slave_shared_pkg::ADDR_SIZE,
  parameter int MEM_DEPTH = 2**ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 err
);
  import slave_shared_pkg::*;

  localparam int CW = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;

  logic                 rx_valid_d, acc;
  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] pl, wr_addr, rd_addr, rd_word;
  logic                 rd_addr_vld, dout_ok;
  logic                 rd_go, wr_go, rd_bad;
  RAM_STATE_e           state, state_nx;
  logic [CW-1:0]        hold_cnt, hold_cnt_nx;

  assign acc = rx_valid & ~rx_valid_d;
  assign cmd = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
  assign pl  = din[ADDR_SIZE-1:0];

  assign wr_go  = acc && (cmd == CMD_WR_DATA);
  // A read in RESP is dropped; a read in IDLE without a fresh RD_ADDR still
  // executes. Both flag err.
  assign rd_bad = acc && (cmd == CMD_RD_DATA) && ((state == RAM_RESP) || !rd_addr_vld);

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    tx_valid    = 1'b0;
    rd_go       = 1'b0;
    case (state)
      RAM_IDLE: begin
        if (acc && (cmd == CMD_RD_DATA)) begin
          rd_go       = 1'b1;
          state_nx    = RAM_RESP;
          hold_cnt_nx = CW'(ADDR_SIZE - 1);
        end
      end
      RAM_RESP: begin
        tx_valid = 1'b1;
        if (hold_cnt == '0) state_nx = RAM_IDLE;
        else                hold_cnt_nx = hold_cnt - 1'b1;
      end
      default: state_nx = RAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RAM_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_addr_vld <= 1'b0;
      err         <= 1'b0;
      dout_ok     <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      err        <= rd_bad;
      if (acc && (cmd == CMD_WR_ADDR)) wr_addr <= pl;
      if (acc && (cmd == CMD_RD_ADDR)) begin
        rd_addr     <= pl;
        rd_addr_vld <= 1'b1;
      end else if (rd_go) begin
        rd_addr_vld <= 1'b0;
      end
      if (rd_go) dout_ok <= 1'b1;
    end
  end

  // The read register inside the RAM has no reset, so dout is masked to zero
  // from reset until the first read lands in it.
  assign dout = dout_ok ? rd_word : '0;

  spi_ram_mem #(.AW(ADDR_SIZE), .DEPTH(MEM_DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_go),
    .waddr (wr_addr),
    .wdata (pl),
    .re    (rd_go),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

endmodule
